alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two operands.
- AND/OR/ADD/SUB complete in one cycle.
- MUL uses an iterative radix-2 shift-add multiplier over WIDTH cycles, under a start/busy/done handshake the pipeline controller uses to stall.
- Sits between the register-file read stage and the writeback/branch logic.

Parameters:
- WIDTH, 32, operand and result width in bits; also the MUL iteration count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only when busy=0.
- alu_ctrl  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 MUL; all other codes illegal.
- a  input  WIDTH  operand A, captured on accept.
- b  input  WIDTH  operand B, captured on accept.
- result  output  WIDTH  registered result, held until the next completion.
- zero  output  1  registered; 1 when result == 0; BEQ uses it after SUB.
- busy  output  1  high while a MUL is iterating.
- done  output  1  one-cycle pulse when result/zero update.
- illegal  output  1  one-cycle pulse, coincident with done, for an unsupported code.

Behaviour:
- Reset (reset=1 at an edge): state IDLE, result=0, zero=1, busy=0, done=0, illegal=0, internal accumulator/multiplicand/multiplier/counter cleared. Reset overrides start and aborts any MUL in progress; no done is produced for the aborted op.
- States: IDLE, MUL.
- IDLE, start=1 at edge E0, code != 0100:
  - Result computed from a/b and registered at E0; done=1 for the cycle after E0 (latency 1).
  - AND: a&b. OR: a|b.
  - ADD: a+b mod 2^WIDTH, carry discarded.
  - SUB: a-b mod 2^WIDTH, borrow discarded.
  - Stay in IDLE.
- IDLE, start=1 at E0, code 0100:
  - Capture a into multiplicand, b into multiplier; accumulator=0; counter=0; busy=1 after E0; go to MUL.
- MUL, each edge:
  - If multiplier[0]=1, accumulator += multiplicand (mod 2^WIDTH).
  - Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - On the edge where counter reaches WIDTH (E_WIDTH; E32 by default): result=accumulator incl. that edge's add, zero updated, done=1, busy=0, return to IDLE.
  - Total latency WIDTH+1 edges (33 default).
  - Product is the low WIDTH bits of a*b; valid for unsigned and two's-complement operands.
- Illegal code: result=0, zero=1, done=1 and illegal=1 together, latency 1.
- start while busy=1: ignored, no queueing. a, b and alu_ctrl changes during MUL have no effect.
- start in the cycle done=1 (busy=0): accepted normally, giving back-to-back single-cycle ops at one per clock.
- done and illegal are never high for more than one consecutive cycle per accepted start.
- result and zero change only on a done edge or on reset.
- No early termination when the multiplier becomes 0; MUL latency is fixed.

Test Plan:
- Reset, then start ADD with a=0x7FFFFFFF, b=1 -> next cycle done=1, result=0x80000000, zero=0, busy=0.
- Back-to-back starts, one per cycle: AND 0xF0F0F0F0&0x0FF00FF0, OR 0x00FF0000|0x000000FF, SUB 5-5 -> done on 3 consecutive cycles; results 0x00F000F0, 0x00FF00FF, 0 with zero=1 on the third.
- MUL a=12345, b=6789 -> busy high for 32 cycles, done exactly 33 cycles after the start edge, result=83810205.
- MUL a=0xFFFFFFFF (-1), b=3 -> result=0xFFFFFFFD. Also, start ADD pulsed during busy is ignored: only one done, no extra result change.
- Start MUL a=0x10000, b=0x10000, assert reset at iteration 10 -> busy=0, result=0, zero=1, no done. A subsequent ADD 2+2 gives 4 with latency 1.
- alu_ctrl=1111 with start -> done=1 and illegal=1 in the same single cycle, result=0, zero=1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle AND/OR/ADD/SUB and an iterative
// shift-add MUL behind a start/busy/done handshake.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_next_s;

    // Next-state: operation decode in IDLE, one shift-add step per cycle in MUL
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        acc_next_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (alu_ctrl)
                        4'b0000: begin
                            result_d = a & b;
                            done_d   = 1'b1;
                        end
                        4'b0001: begin
                            result_d = a | b;
                            done_d   = 1'b1;
                        end
                        4'b0010: begin
                            result_d = a + b;
                            done_d   = 1'b1;
                        end
                        4'b0011: begin
                            result_d = a - b;
                            done_d   = 1'b1;
                        end
                        4'b0100: begin
                            mcand_d  = a;
                            mplier_d = b;
                            acc_d    = '0;
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = ST_MUL;
                        end
                        default: begin
                            result_d  = '0;
                            done_d    = 1'b1;
                            illegal_d = 1'b1;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // Fixed latency: no early exit once the multiplier drains to zero
                acc_d    = acc_next_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    result_d = acc_next_s;
                    zero_d   = (acc_next_s == '0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;

endmodule
